// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: same-cycle fetch lookup, execute-stage write-back.
// BTB_LRU_EN selects true per-set LRU; otherwise a per-set round-robin victim pointer is used.
module btb_assoc #(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 2
) (
    input  logic        clk,
    input  logic        reset_ni,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] BTBwritedata_i,
    input  logic        J_i,
    input  logic        B_i,
    input  logic        PHTincrement_i,
    output logic [31:0] BTBtarget_o,
    output logic        jumphit_o,
    output logic        branchhit_o,
    output logic        branchtaken_en
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 30 - IDX_W;
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    logic             valid_q [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0] tag_q   [NUM_SETS][NUM_WAYS];
    logic [31:0]      tgt_q   [NUM_SETS][NUM_WAYS];
    logic             jmp_q   [NUM_SETS][NUM_WAYS];
    logic             br_q    [NUM_SETS][NUM_WAYS];

    logic [31:2] pc_d, pc_e;
    logic        v_d, v_e;

    logic [IDX_W-1:0] f_set, e_set;
    logic [TAG_W-1:0] f_tag, e_tag;
    logic             f_hit, e_hit;
    logic [WAY_W-1:0] f_way, e_way;
    logic             set_full;
    logic [WAY_W-1:0] inv_way, victim, alloc_way, w_way;
    logic             take, we, e_touch, do_alloc;
    logic             unused;

    assign unused = ^pc_i[1:0];

    assign f_set = pc_i[IDX_W+1:2];
    assign f_tag = pc_i[31:IDX_W+2];
    assign e_set = pc_e[IDX_W+1:2];
    assign e_tag = pc_e[31:IDX_W+2];

    always_comb begin
        f_hit = 1'b0;
        f_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[f_set][w] && tag_q[f_set][w] == f_tag) begin
                f_hit = 1'b1;
                f_way = WAY_W'(w);
            end
        end
    end

    // Independent compare for E: writes since this PC was in F may have changed the set.
    always_comb begin
        e_hit = 1'b0;
        e_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[e_set][w] && tag_q[e_set][w] == e_tag) begin
                e_hit = 1'b1;
                e_way = WAY_W'(w);
            end
        end
    end

    assign BTBtarget_o    = f_hit ? tgt_q[f_set][f_way] : 32'h0;
    assign jumphit_o      = f_hit & jmp_q[f_set][f_way];
    assign branchhit_o    = f_hit & br_q[f_set][f_way];
    assign branchtaken_en = f_hit;

    // Lowest-index invalid way wins; scanning downward leaves the smallest index last.
    always_comb begin
        set_full = 1'b1;
        inv_way  = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[e_set][w]) begin
                set_full = 1'b0;
                inv_way  = WAY_W'(w);
            end
        end
    end

    assign take      = J_i | PHTincrement_i;
    assign we        = v_e & ~stall_i;
    assign e_touch   = we & take;
    assign do_alloc  = we & take & ~e_hit;
    assign alloc_way = set_full ? victim : inv_way;
    assign w_way     = e_hit ? e_way : alloc_way;

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            pc_d <= '0;
            pc_e <= '0;
            v_d  <= 1'b0;
            v_e  <= 1'b0;
        end else if (!stall_i) begin
            pc_d <= pc_i[31:2];
            pc_e <= pc_d;
            v_d  <= ~flush_i;
            v_e  <= v_d & ~flush_i;
        end
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    tgt_q[s][w]   <= '0;
                    jmp_q[s][w]   <= 1'b0;
                    br_q[s][w]    <= 1'b0;
                end
            end
        end else if (we) begin
            if (e_hit) begin
                if (take) begin
                    tgt_q[e_set][e_way] <= BTBwritedata_i;
                    jmp_q[e_set][e_way] <= J_i;
                    br_q[e_set][e_way]  <= B_i;
                end else if (!B_i) begin
                    // Entry aliased onto a non-branch instruction.
                    valid_q[e_set][e_way] <= 1'b0;
                end
            end else if (take) begin
                valid_q[e_set][alloc_way] <= 1'b1;
                tag_q[e_set][alloc_way]   <= e_tag;
                tgt_q[e_set][alloc_way]   <= BTBwritedata_i;
                jmp_q[e_set][alloc_way]   <= J_i;
                br_q[e_set][alloc_way]    <= B_i;
            end
        end
    end

    if (NUM_WAYS > 1) begin : g_policy
`ifdef BTB_LRU_EN
        logic [WAY_W-1:0] age_q [NUM_SETS][NUM_WAYS];
        logic [WAY_W-1:0] age_n [NUM_SETS][NUM_WAYS];

        always_comb begin
            victim = '0;
            for (int w = 1; w < NUM_WAYS; w++) begin
                if (age_q[e_set][w] > age_q[e_set][victim]) victim = WAY_W'(w);
            end
        end

        // F touch first, then E touch, so an E write to the same set ends MRU.
        always_comb begin
            logic [WAY_W-1:0] ref_age;
            age_n   = age_q;
            ref_age = '0;
            if (!stall_i && f_hit) begin
                ref_age = age_n[f_set][f_way];
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_W'(w) == f_way) age_n[f_set][w] = '0;
                    else if (age_n[f_set][w] <= ref_age && age_n[f_set][w] != {WAY_W{1'b1}})
                        age_n[f_set][w] = age_n[f_set][w] + 1'b1;
                end
            end
            if (e_touch) begin
                ref_age = age_n[e_set][w_way];
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_W'(w) == w_way) age_n[e_set][w] = '0;
                    else if (age_n[e_set][w] <= ref_age && age_n[e_set][w] != {WAY_W{1'b1}})
                        age_n[e_set][w] = age_n[e_set][w] + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_ni) begin
            if (!reset_ni) begin
                for (int s = 0; s < NUM_SETS; s++)
                    for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= '0;
            end else if (!stall_i) begin
                age_q <= age_n;
            end
        end
`else
        logic [WAY_W-1:0] ptr_q [NUM_SETS];

        assign victim = ptr_q[e_set];

        always_ff @(posedge clk or negedge reset_ni) begin
            if (!reset_ni) begin
                for (int s = 0; s < NUM_SETS; s++) ptr_q[s] <= '0;
            end else if (do_alloc && set_full) begin
                ptr_q[e_set] <= ptr_q[e_set] + 1'b1;
            end
        end
`endif
    end else begin : g_direct
        assign victim = '0;
    end

endmodule

// File: doc/btb_assoc.md
# btb_assoc

Set-associative branch target buffer for the fetch stage, successor to the direct-mapped BTB. It performs a same-cycle fetch lookup on `pc_i` and returns the predicted target and the jump/branch class. Resolved branches are written back from execute into the same tables. Sets and ways are parameterised, with a replacement policy and a stall/flush-aware internal F→D→E PC pipeline, so it can sit directly beside the PHT in the branch predictor.

## Interface
- `NUM_SETS`, 16: number of sets; power of two, ≥2. `IDX_W = $clog2(NUM_SETS)`, `TAG_W = 30-IDX_W`.
- `NUM_WAYS`, 2: ways per set; power of two, 1..8.
- `clk`  in  1  sole clock, rising edge.
- `reset_ni`  in  1  asynchronous, active-low reset.
- `pc_i`  in  32  fetch PC (F).
- `stall_i`  in  1  pipeline stall; holds internal D/E registers and suppresses writes/LRU updates.
- `flush_i`  in  1  execute-stage redirect; kills in-flight F/D lookups.
- `BTBwritedata_i`  in  32  resolved target (E).
- `J_i`  in  1  E instruction is a jump.
- `B_i`  in  1  E instruction is a conditional branch.
- `PHTincrement_i`  in  1  E branch resolved taken.
- `BTBtarget_o`  out  32  predicted target; 0 on miss.
- `jumphit_o`  out  1  hit entry is a jump; 0 on miss.
- `branchhit_o`  out  1  hit entry is a branch; 0 on miss.
- `branchtaken_en`  out  1  hit in F.

## Operation
- Index is `pc[IDX_W+1:2]` and tag is `pc[31:IDX_W+2]`. Each way holds valid, tag, target, J and B.
- F lookup (combinational): hit when some way in the set is valid with a matching tag.
  - Outputs come from that way; all outputs are 0 on a miss.
  - At most one way can match. The write rule guarantees this.
- Internal pipeline: registers `pc_d`/`v_d` and `pc_e`/`v_e`.
  - When `!stall_i`: `pc_d<=pc_i`, `v_d<=1`, `pc_e<=pc_d`, `v_e<=v_d`.
  - `flush_i` (when not stalled) forces `v_d<=0` and `v_e<=0` at the next edge.
  - `stall_i` has priority over `flush_i`.
- E lookup: a second combinational tag compare of `pc_e` against its set. It never reuses the F result, because intervening writes may have changed the set.
- Write enable `we = v_e & !stall_i`. Action by case:
  - `J_i | PHTincrement_i`, E hit: overwrite the hit way (target, J, B). Tag and valid are unchanged.
  - `J_i | PHTincrement_i`, E miss: allocate the lowest-index invalid way, otherwise the policy victim. Write the tag, valid=1, target, J and B.
  - E hit with `!J_i & !B_i` (entry aliased to a non-branch): clear that way's valid.
  - Otherwise: no change. A not-taken branch never allocates and never evicts.
- The E write occurs in the same cycle `flush_i` is asserted, because the flushing instruction is itself in E.
- Policy state update (only when `!stall_i`):
  - Way touched by a write or an F hit becomes MRU.
  - If an E write and an F hit update the same set in one cycle, the E-written way ends MRU.
- `NUM_WAYS=1` degenerates to a direct-mapped BTB; the policy logic is absent.

## Timing
- F lookup: 0-cycle latency, combinational from `pc_i` and the stored state.
- Write: visible to F lookups from the cycle after the write edge. There is no bypass; a same-cycle F lookup of the written set sees the old contents.
- E corresponds to the `pc_i` of 2 unstalled cycles earlier.
- Reset (async assert, synchronous-safe release):
  - All valid bits, `v_d` and `v_e` are 0.
  - Tags, targets and policy state are 0.
  - All outputs read 0 while any reset is in effect and until the first allocation.
- Reset asserted mid-operation discards any pending write. No write occurs on the edge on which reset deasserts, because `v_e=0`.

## Configuration
- `BTB_LRU_EN` defined: true LRU per set, using per-way `$clog2(NUM_WAYS)`-bit age counters.
  - Touched way goes to age 0; younger ways age by 1.
  - Victim is the way with maximum age.
- `BTB_LRU_EN` undefined: per-set round-robin pointer, advanced only on a miss allocation into a full set. F hits do not update it.
- Allocation into an invalid way never consults or advances the pointer.

## Test plan
- Reset, then `pc_i=0x100` with no writes: all outputs 0. Issue `J_i=1`, `BTBwritedata_i=0x400` with 0x100 in E; then `pc_i=0x100` returns `BTBtarget_o=0x400`, `jumphit_o=1`, `branchtaken_en=1`.
- NUM_SETS=16, NUM_WAYS=2: allocate 0x100, 0x140 and 0x180 (same set). With `BTB_LRU_EN`, touching 0x100 between allocations makes 0x140 the one evicted. Without the macro, 0x100 is evicted.
- Branch 0x200 in E with `B_i=1` and `PHTincrement_i=0`, not present in the BTB: no allocation, and later lookup of 0x200 misses. Same with `PHTincrement_i=1`: allocates with `branchhit_o=1`.
- Entry 0x300 present; E instruction at 0x300 with `J_i=B_i=0`: entry invalidated, next lookup of 0x300 misses.
- `stall_i=1` for 3 cycles with a taken jump in E: no write until stall drops, then exactly one write. `flush_i` pulse: the two younger PCs produce no writes even with `J_i=1`.
- Write 0x100 and look up 0x100 in F on the same cycle: miss. Next cycle: hit.
